// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (IF/DATA/PTW) for the single external memory port.
// Fixed priority PTW > DATA > IF with an IF starvation guard and a slave timeout.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [2:0]              m_req,
    input  logic [2:0]              m_we,
    input  logic [3*ADDR_W-1:0]     m_addr,
    input  logic [3*DATA_W-1:0]     m_wdata,
    input  logic [3*(DATA_W/8)-1:0] m_wmask,
    output logic [2:0]              m_done,
    output logic [2:0]              m_err,
    output logic [2:0]              m_stall,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    s_re,
    output logic                    s_we,
    output logic [ADDR_W-1:0]       s_addr,
    output logic [DATA_W-1:0]       s_wdata,
    output logic [DATA_W/8-1:0]     s_wmask,
    input  logic                    s_ready,
    input  logic [DATA_W-1:0]       s_rdata,
    output logic                    busy,
    output logic [1:0]              grant
);
    localparam int MASK_W = DATA_W / 8;
    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic            we_l;
    logic [TO_W-1:0] to_cnt;
    logic [SC_W-1:0] starve_cnt;
    logic [1:0]      win;

    // IF is forced once it has watched STARVE_LIMIT higher-priority grants go by
    always_comb begin
        win = 2'd0;
        if (m_req[0] && starve_cnt == SC_MAX) win = 2'd0;
        else if (m_req[2])                    win = 2'd2;
        else if (m_req[1])                    win = 2'd1;
    end

    assign m_stall = m_req & ~m_done;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            we_l       <= 1'b0;
            to_cnt     <= '0;
            starve_cnt <= '0;
            grant      <= 2'd3;
            m_done     <= '0;
            m_err      <= '0;
            m_rdata    <= '0;
            s_re       <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wmask    <= '0;
        end else begin
            s_re   <= 1'b0;
            s_we   <= 1'b0;
            m_done <= '0;
            m_err  <= '0;
            case (state)
                IDLE: if (|m_req) begin
                    grant   <= win;
                    we_l    <= m_we[win];
                    s_re    <= ~m_we[win];
                    s_we    <= m_we[win];
                    s_addr  <= m_addr[32'(win)*ADDR_W +: ADDR_W];
                    s_wdata <= m_wdata[32'(win)*DATA_W +: DATA_W];
                    s_wmask <= m_wmask[32'(win)*MASK_W +: MASK_W];
                    if (win == 2'd0)
                        starve_cnt <= '0;
                    else if (m_req[0])
                        starve_cnt <= (starve_cnt == SC_MAX) ? SC_MAX : starve_cnt + 1'b1;
                    else
                        starve_cnt <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (s_ready) begin
                        m_rdata <= we_l ? '0 : s_rdata;
                        m_done  <= 3'b001 << grant;
                        state   <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        m_rdata <= '0;
                        m_done  <= 3'b001 << grant;
                        m_err   <= 3'b001 << grant;
                        state   <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    grant <= 2'd3;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
